// File: rtl/bitwise_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_logic_pipe
// Brief    : WIDTH-bit bitwise logic unit with XOR-accumulate mode,
//            registered result stage and valid/ready handshakes.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module bitwise_logic_pipe #(
    parameter int WIDTH      = 32,
    parameter int ACC_BEATS  = 4,
    parameter int GATE_DELAY = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_acc
);

    localparam int C_CNT_W = $clog2(ACC_BEATS + 1);

    localparam logic [2:0] C_OP_AND  = 3'b000;
    localparam logic [2:0] C_OP_OR   = 3'b001;
    localparam logic [2:0] C_OP_XOR  = 3'b010;
    localparam logic [2:0] C_OP_NAND = 3'b011;
    localparam logic [2:0] C_OP_NOR  = 3'b100;
    localparam logic [2:0] C_OP_XNOR = 3'b101;
    localparam logic [2:0] C_OP_ACC  = 3'b110;
    localparam logic [2:0] C_OP_CLR  = 3'b111;

    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(ACC_BEATS - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    // Accumulator states: IDLE means no partial sum is held.
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    // Reject illegal parameterisations at elaboration time. GATE_DELAY only
    // shapes simulation timing of gate models, so synthesis just checks sign.
    generate
        if (WIDTH < 1 || ACC_BEATS < 1 || GATE_DELAY < 0) begin : g_param_check
            $error("bitwise_logic_pipe: illegal parameter value");
        end
    endgenerate

    logic [0:0]         r_state;
    logic [C_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_acc;

    logic               w_accept;
    logic               w_consume;
    logic               w_is_logic;
    logic               w_acc_last;
    logic               w_load;
    logic [WIDTH-1:0]   w_acc_base;
    logic [WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]   w_logic;
    logic [WIDTH-1:0]   w_load_data;

    // Handshake: the register can take a beat when empty or being drained.
    always_comb begin
        in_ready  = !out_valid || out_ready;
        w_accept  = in_valid && in_ready;
        w_consume = out_valid && out_ready;
    end

    // Bitwise op selection, accumulate fold, and output-load decision.
    always_comb begin
        w_logic = '0;
        case (op)
            C_OP_AND:  w_logic = a & b;
            C_OP_OR:   w_logic = a | b;
            C_OP_XOR:  w_logic = a ^ b;
            C_OP_NAND: w_logic = ~(a & b);
            C_OP_NOR:  w_logic = ~(a | b);
            C_OP_XNOR: w_logic = ~(a ^ b);
            default:   w_logic = '0;
        endcase
        // In IDLE the running sum is by definition empty.
        w_acc_base  = (r_state == S_IDLE) ? '0 : r_acc;
        w_acc_next  = w_acc_base ^ a ^ b;
        w_is_logic  = (op != C_OP_ACC) && (op != C_OP_CLR);
        w_acc_last  = (op == C_OP_ACC) && (r_count == C_CNT_LAST);
        w_load      = w_accept && (w_is_logic || w_acc_last);
        w_load_data = w_is_logic ? w_logic : w_acc_next;
    end

    // Result register: load on a producing beat, otherwise drain on consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b0;
            out_acc   <= 1'b0;
        end else if (w_load) begin
            out_valid <= 1'b1;
            out_data  <= w_load_data;
            out_zero  <= (w_load_data == '0);
            out_acc   <= !w_is_logic;
        end else if (w_consume) begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator FSM: folds ACC beats, emits on the last one, CLR restarts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_acc   <= '0;
        end else if (w_accept) begin
            if (op == C_OP_CLR || w_acc_last) begin
                r_state <= S_IDLE;
                r_count <= '0;
                r_acc   <= '0;
            end else if (op == C_OP_ACC) begin
                r_state <= S_ACCUM;
                r_count <= r_count + C_CNT_ONE;
                r_acc   <= w_acc_next;
            end
        end
    end

endmodule
`default_nettype wire
